// File: rtl/wordline_decode_seq.sv
// Word-line decoder with direct-decode and timed sweep modes (IDLE/SWEEP/XTRA/DONE).
// Define WORDLINE_DECODE_SEQ_ONEHOT_CHK_EN to add the sticky err output flagging illegal w patterns.
module wordline_decode_seq #(
  parameter int AW    = 3,
  parameter int DWELL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [AW:0]     d,
  input  logic            load,
  input  logic            start,
  output logic            ready,
  output logic            busy,
  output logic            done,
`ifdef WORDLINE_DECODE_SEQ_ONEHOT_CHK_EN
  output logic [(2**AW):0] w,
  output logic            err
`else
  output logic [(2**AW):0] w
`endif
);

  localparam int NW = (2 ** AW) + 1;
  localparam logic [AW-1:0] LAST  = {AW{1'b1}};
  localparam logic [7:0]    DLAST = 8'(DWELL - 1);
  localparam logic [NW-1:0] XBIT  = {1'b1, {(NW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SWEEP, XTRA, DONE} state_t;

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nx;
  logic [7:0]    cnt;
  logic          xreq;

  function automatic logic [NW-1:0] onehot(input logic [AW-1:0] i);
    logic [NW-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Base line from the index; extension line only rides along with index 0.
  function automatic logic [NW-1:0] decode(input logic [AW:0] v);
    logic [NW-1:0] r;
    r         = onehot(v[AW-1:0]);
    r[NW-1]   = (v[AW-1:0] == '0) & v[AW];
    return r;
  endfunction

  assign idx_nx = idx + AW'(1);
  assign ready  = (state == IDLE) & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      w     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
      cnt   <= '0;
      xreq  <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      w     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
      cnt   <= '0;
      xreq  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= SWEEP;
            busy  <= 1'b1;
            xreq  <= d[AW];
            idx   <= '0;
            cnt   <= '0;
            w     <= onehot('0);
          end else if (load) begin
            w <= decode(d);
          end
        end
        SWEEP: begin
          if (cnt == DLAST) begin
            cnt <= '0;
            // Last base line: never wrap the index, branch to extension or finish.
            if (idx == LAST) begin
              if (xreq) begin
                state <= XTRA;
                w     <= XBIT;
              end else begin
                state <= DONE;
                w     <= '0;
                done  <= 1'b1;
              end
            end else begin
              idx <= idx_nx;
              w   <= onehot(idx_nx);
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        XTRA: begin
          if (cnt == DLAST) begin
            cnt   <= '0;
            state <= DONE;
            w     <= '0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          idx   <= '0;
          xreq  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WORDLINE_DECODE_SEQ_ONEHOT_CHK_EN
  localparam logic [NW-1:0] PAIR = XBIT | NW'(1);
  logic illegal;

  // Legal: zero, any single line, or line 0 together with the extension line.
  assign illegal = ((w & (w - NW'(1))) != '0) && (w != PAIR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clear) begin
      err <= 1'b0;
    end else if (illegal) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wordline_decode_seq.sv
// Bench for wordline_decode_seq: two instances (DWELL=1 and DWELL=3) share stimulus and are
// checked every cycle against a sweep-position model, plus literal expectations.
module tb_wordline_decode_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       load  = 1'b0;
  logic       start = 1'b0;
  logic [3:0] d     = 4'd0;

  logic [1:0][8:0] wv;
  logic [1:0]      rdy, bsy, dn;
`ifdef WORDLINE_DECODE_SEQ_ONEHOT_CHK_EN
  logic [1:0]      er;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wordline_decode_seq #(.AW(3), .DWELL(1)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .d(d), .load(load), .start(start),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
`ifdef WORDLINE_DECODE_SEQ_ONEHOT_CHK_EN
    .w(wv[0]), .err(er[0])
`else
    .w(wv[0])
`endif
  );

  wordline_decode_seq #(.AW(3), .DWELL(3)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .d(d), .load(load), .start(start),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
`ifdef WORDLINE_DECODE_SEQ_ONEHOT_CHK_EN
    .w(wv[1]), .err(er[1])
`else
    .w(wv[1])
`endif
  );

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Model: a sweep is a cycle position p; line = p / dwell, extension after the base lines.
  function automatic int dwell_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [8:0] sweep_w(input int p, input int dw);
    int line;
    line = p / dw;
    if (line < 8) return 9'(1 << line);
    return 9'h100;
  endfunction

  function automatic logic [8:0] dec(input logic [3:0] v);
    logic [8:0] r;
    r = 9'(1 << v[2:0]);
    if (v[2:0] == 3'd0 && v[3]) r[8] = 1'b1;
    return r;
  endfunction

  logic [8:0] ew [2];
  logic       eb [2];
  logic       ed [2];
  logic       act [2];
  logic       xr [2];
  int         pos [2];

  initial begin
    int len;
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          act[k] = 1'b0; eb[k] = 1'b0; ed[k] = 1'b0; ew[k] = '0; pos[k] = 0; xr[k] = 1'b0;
        end else if (clear) begin
          act[k] = 1'b0; eb[k] = 1'b0; ed[k] = 1'b0; ew[k] = '0;
        end else if (act[k]) begin
          len = (8 + (xr[k] ? 1 : 0)) * dwell_of(k);
          pos[k]++;
          if (pos[k] < len) begin
            ew[k] = sweep_w(pos[k], dwell_of(k));
          end else if (pos[k] == len) begin
            ew[k] = '0; ed[k] = 1'b1;
          end else begin
            act[k] = 1'b0; eb[k] = 1'b0; ed[k] = 1'b0;
          end
        end else begin
          ed[k] = 1'b0;
          if (start) begin
            act[k] = 1'b1; eb[k] = 1'b1; pos[k] = 0; xr[k] = d[3];
            ew[k] = sweep_w(0, dwell_of(k));
          end else if (load) begin
            ew[k] = dec(d);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d_w", k), wv[k], ew[k]);
        chk($sformatf("u%0d_busy", k), 9'(bsy[k]), 9'(eb[k]));
        chk($sformatf("u%0d_done", k), 9'(dn[k]), 9'(ed[k]));
        chk($sformatf("u%0d_ready", k), 9'(rdy[k]), 9'(!eb[k] && !clear));
`ifdef WORDLINE_DECODE_SEQ_ONEHOT_CHK_EN
        chk($sformatf("u%0d_err", k), 9'(er[k]), 9'd0);
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] seq [10];
    int busycnt;
    seq = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080, 9'h100, 9'h000};

    repeat (3) step();
    chk("rst_w", wv[0], 9'h000);
    chk("rst_busy", 9'(bsy[0]), 9'd0);
    chk("rst_done", 9'(dn[0]), 9'd0);
    chk("rst_ready", 9'(rdy[0]), 9'd1);
    rst_n = 1'b1;
    step();

    // Direct decode
    d = 4'b1000; load = 1'b1; step(); load = 1'b0;
    chk("load_1000", wv[0], 9'h101);
    d = 4'b0101; load = 1'b1; step(); load = 1'b0;
    chk("load_0101", wv[0], 9'h020);
    step();
    chk("load_hold", wv[0], 9'h020);

    // Full sweep with extension line
    d = 4'b1000; start = 1'b1; step(); start = 1'b0;
    busycnt = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("sweep_w%0d", i), wv[0], seq[i]);
      chk($sformatf("sweep_done%0d", i), 9'(dn[0]), 9'(i == 9));
      busycnt += int'(bsy[0]);
      step();
    end
    chk("sweep_busycnt", 9'(busycnt), 9'd10);
    chk("sweep_idle", 9'(bsy[0]), 9'd0);
    repeat (20) step();

    // Dwell of 3, no extension line
    d = 4'b0000; start = 1'b1; step(); start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c <= 24) chk($sformatf("dwell_w%0d", c), wv[1], 9'(1 << ((c - 1) / 3)));
      else begin
        chk("dwell_done25", 9'(dn[1]), 9'd1);
        chk("dwell_w25", wv[1], 9'h000);
      end
      step();
    end
    repeat (3) step();

    // Clear mid-sweep
    d = 4'b0000; start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    chk("clr_pre_w", wv[0], 9'h008);
    clear = 1'b1; #1;
    chk("clr_ready_low", 9'(rdy[0]), 9'd0);
    step(); clear = 1'b0; #1;
    chk("clr_w", wv[0], 9'h000);
    chk("clr_busy", 9'(bsy[0]), 9'd0);
    chk("clr_ready", 9'(rdy[0]), 9'd1);
    for (int i = 0; i < 3; i++) begin
      chk("clr_nodone", 9'(dn[0]), 9'd0);
      step();
    end

    // Start beats load; load while busy is ignored
    d = 4'b0101; start = 1'b1; load = 1'b1; step(); start = 1'b0; load = 1'b0;
    chk("prio_w", wv[0], 9'h001);
    chk("prio_busy", 9'(bsy[0]), 9'd1);
    d = 4'b0011; load = 1'b1; step(); load = 1'b0;
    chk("busy_load_w", wv[0], 9'h002);
    repeat (30) step();

    // Asynchronous reset mid-sweep
    d = 4'b1000; start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("arst_pre_w", wv[0], 9'h004);
    rst_n = 1'b0; #1;
    chk("arst_w0", wv[0], 9'h000);
    chk("arst_busy0", 9'(bsy[0]), 9'd0);
    chk("arst_w1", wv[1], 9'h000);
    chk("arst_busy1", 9'(bsy[1]), 9'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("arst_post_busy", 9'(bsy[0]), 9'd0);
      chk("arst_post_done", 9'(dn[0]), 9'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
